// File: rtl/ahb_mbox_pkg.sv
// Shared definitions for the AHB mailbox target: transfer codes, register map,
// STATUS bit layout and the bus-side FSM state encoding.
package ahb_mbox_pkg;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam int unsigned OFF_TXDATA = 'h00;
    localparam int unsigned OFF_RXDATA = 'h04;
    localparam int unsigned OFF_STATUS = 'h08;
    localparam int unsigned OFF_IRQEN  = 'h0C;

    localparam int STS_RX_NONEMPTY = 0;
    localparam int STS_TX_FULL     = 1;
    localparam int STS_TX_EMPTY    = 2;
    localparam int STS_RX_CNT_LSB  = 8;
    localparam int STS_TX_CNT_LSB  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } mbox_state_e;

    function automatic logic [31:0] pack_status(
        input logic       rx_nonempty,
        input logic       tx_full,
        input logic       tx_empty,
        input logic [7:0] rx_cnt,
        input logic [7:0] tx_cnt
    );
        logic [31:0] s;
        s = '0;
        s[STS_RX_NONEMPTY]       = rx_nonempty;
        s[STS_TX_FULL]           = tx_full;
        s[STS_TX_EMPTY]          = tx_empty;
        s[STS_RX_CNT_LSB +: 8]   = rx_cnt;
        s[STS_TX_CNT_LSB +: 8]   = tx_cnt;
        return s;
    endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Synchronous word FIFO with occupancy count. A push while full is accepted only
// when a pop happens in the same cycle; there is no empty-to-output bypass.
module mbox_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    import ahb_mbox_pkg::*;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_en  = push & (~full | pop);
    assign pop_en   = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ahb_mailbox_target.sv
// AHB-Lite mailbox target bridging CPU accesses to TX/RX word FIFOs.
// Optional interrupt logic is enabled by defining AHB_MBOX_IRQ_EN.
module ahb_mailbox_target #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADYMUX,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic              TXVALID,
    input  logic              TXREADY,
    output logic [31:0]       TXDATA,
    input  logic              RXVALID,
    output logic              RXREADY,
    input  logic [31:0]       RXDATA,
    output logic              IRQ
);
    import ahb_mbox_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    mbox_state_e state_q, state_d;
    logic        hready_q, hready_d;
    logic        hresp_q, hresp_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic [1:0]  wait_q, wait_d;
    logic        tx_pend_q, tx_pend_d;
    logic        irqen_pend_q, irqen_pend_d;
    logic        run_q;

    logic          tx_full, tx_empty, tx_pop;
    logic [CW-1:0] tx_count;
    logic          rx_full, rx_empty, rx_push, rx_pop;
    logic [CW-1:0] rx_count;
    logic [31:0]   rx_head;
    logic [1:0]    irqen_rd;

    logic          accept, acc_err;
    logic          sel_tx, sel_rx, sel_sts, sel_irqen;
    logic [CW:0]   tx_level;
    logic [31:0]   status, rd_data;

    mbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (tx_pend_q),
        .push_data (HWDATA),
        .pop       (tx_pop),
        .pop_data  (TXDATA),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    mbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (rx_push),
        .push_data (RXDATA),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign TXVALID   = ~tx_empty;
    assign tx_pop    = TXVALID & TXREADY;
    assign RXREADY   = run_q & ~rx_full;
    assign rx_push   = RXVALID & RXREADY;
    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

    assign sel_tx    = (HADDR == ADDR_W'(OFF_TXDATA));
    assign sel_rx    = (HADDR == ADDR_W'(OFF_RXDATA));
    assign sel_sts   = (HADDR == ADDR_W'(OFF_STATUS));
    assign sel_irqen = (HADDR == ADDR_W'(OFF_IRQEN));

    assign accept = HSEL & HREADYMUX & hready_q &
                    ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

    // A push still in its data phase counts against TX space, so a pipelined
    // write stream cannot overrun the FIFO.
    assign tx_level = {1'b0, tx_count} + {{CW{1'b0}}, tx_pend_q};

    assign status = pack_status(~rx_empty, tx_full, tx_empty,
                                8'(rx_count), 8'(tx_count));

    always_comb begin
        acc_err = 1'b0;
        if (HSIZE != HSIZE_WORD) begin
            acc_err = 1'b1;
        end else if (HWRITE) begin
            if (sel_tx)         acc_err = (tx_level == (CW+1)'(DEPTH));
            else if (!sel_irqen) acc_err = 1'b1;
        end else begin
            if (sel_rx)         acc_err = rx_empty;
            else if (!(sel_sts || sel_irqen)) acc_err = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel_rx)         rd_data = rx_head;
        else if (sel_sts)   rd_data = status;
        else if (sel_irqen) rd_data = {30'b0, irqen_rd};
    end

    // Next-state for the bus FSM; every decision about a transfer is taken at acceptance.
    always_comb begin
        state_d      = state_q;
        hready_d     = hready_q;
        hresp_d      = hresp_q;
        hrdata_d     = hrdata_q;
        wait_d       = wait_q;
        tx_pend_d    = 1'b0;
        irqen_pend_d = 1'b0;
        rx_pop       = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (wait_q == 2'd0) begin
                    state_d  = ST_IDLE;
                    hready_d = 1'b1;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_ERR1: begin
                state_d  = ST_ERR2;
                hready_d = 1'b1;
                hresp_d  = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                hready_d = 1'b1;
                hresp_d  = 1'b0;
            end
        endcase

        if (accept) begin
            if (acc_err) begin
                state_d  = ST_ERR1;
                hready_d = 1'b0;
                hresp_d  = 1'b1;
            end else if (HWRITE) begin
                tx_pend_d    = sel_tx;
                irqen_pend_d = sel_irqen;
            end else begin
                hrdata_d = rd_data;
                rx_pop   = sel_rx;
                if (WAIT_STATES > 0) begin
                    state_d  = ST_WAIT;
                    hready_d = 1'b0;
                    wait_d   = 2'(WAIT_STATES - 1);
                end
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            hready_q     <= 1'b1;
            hresp_q      <= 1'b0;
            hrdata_q     <= '0;
            wait_q       <= '0;
            tx_pend_q    <= 1'b0;
            irqen_pend_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hready_q     <= hready_d;
            hresp_q      <= hresp_d;
            hrdata_q     <= hrdata_d;
            wait_q       <= wait_d;
            tx_pend_q    <= tx_pend_d;
            irqen_pend_q <= irqen_pend_d;
            run_q        <= 1'b1;
        end
    end

`ifdef AHB_MBOX_IRQ_EN
    logic [1:0] irqen_q, irqen_d;
    logic       irq_q, irq_d;

    always_comb begin
        irqen_d = irqen_pend_q ? HWDATA[1:0] : irqen_q;
        irq_d   = |(irqen_q & {tx_empty, ~rx_empty});
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            irqen_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
        end
    end

    assign irqen_rd = irqen_q;
    assign IRQ      = irq_q;
`else
    logic unused_irqen;
    assign unused_irqen = irqen_pend_q;
    assign irqen_rd     = '0;
    assign IRQ          = 1'b0;
`endif

endmodule
